// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its sharing scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   alu_op_e        - 2-bit ALU operation code
//   CF_ZF/SF/OF     - bit positions inside the 3-bit {ZF, SF, OF} flag vector
//   ALU_W_DEFAULT   - default operand/result width
//   sched_state_e   - response buffer occupancy state
package alu_pkg;

    localparam int ALU_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    // Flag vector layout is {ZF, SF, OF}.
    localparam int CF_ZF = 2;
    localparam int CF_SF = 1;
    localparam int CF_OF = 0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/alu.sv
// Execute-stage ALU: add/sub/and/xor on W-bit two's complement operands plus flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   ctrl  in  2  operation (alu_op_e encoding)
//   a, b  in  W  signed operands
//   out   out W  result, wraps modulo 2^W
//   cf    out 3  {ZF, SF, OF} of the result
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W_DEFAULT
) (
    input  logic [1:0]   ctrl,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out,
    output logic [2:0]   cf
);

    logic [W-1:0] res;
    logic         ovf;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (alu_op_e'(ctrl))
            ALU_ADD: begin
                res = a + b;
                // Signed overflow: operands agree in sign, result does not.
                ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                res = a - b;
                // Signed overflow: operands differ in sign, result sign flips from a.
                ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            ALU_AND: res = a & b;
            ALU_XOR: res = a ^ b;
            default: res = '0;
        endcase
    end

    always_comb begin
        cf        = 3'b000;
        cf[CF_ZF] = (res == '0);
        cf[CF_SF] = res[W-1];
        cf[CF_OF] = ovf;
    end

    assign out = res;

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin sharing of one ALU between two requesters, one-entry response buffer, CC register.
// Latency: request accepted at edge k, response and CC visible right after edge k.
// Backpressure: both readies drop while the buffer is full and rsp_ready is low; drain+refill in one cycle.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req0_* / req1_*               valid/ready request ports with ctrl, a, b (req0 also set_cc)
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_out, rsp_cf       owner, result and flags of the buffered response
//   cc                            architectural condition codes {ZF, SF, OF}
module alu_share_sched
    import alu_pkg::*;
#(
    parameter int W = ALU_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_ctrl,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_set_cc,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_ctrl,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_out,
    output logic [2:0]   rsp_cf,

    output logic [2:0]   cc
);

    sched_state_e state;
    sched_state_e state_nxt;

    logic         ptr;        // preferred port when both are valid
    logic         grant;      // 0 when nobody requests, so the mux falls back to port 0
    logic         has_req;
    logic         can_accept;
    logic         accept;

    logic [1:0]   alu_ctrl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic [2:0]   alu_cf;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    always_comb begin
        has_req = req0_valid | req1_valid;
        grant   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand mux into the shared ALU
    // ------------------------------------------------------------------
    always_comb begin
        alu_ctrl = req0_ctrl;
        alu_a    = req0_a;
        alu_b    = req0_b;
        if (grant) begin
            alu_ctrl = req1_ctrl;
            alu_a    = req1_a;
            alu_b    = req1_b;
        end
    end

    alu #(
        .W (W)
    ) u_alu (
        .ctrl (alu_ctrl),
        .a    (alu_a),
        .b    (alu_b),
        .out  (alu_out),
        .cf   (alu_cf)
    );

    // ------------------------------------------------------------------
    // Response buffer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        can_accept = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        // A full buffer can still take a new op when it is being drained this cycle.
        can_accept = (state == EMPTY) || rsp_ready;

        // Readies are held low during reset so nothing is handshaken
        // while the registers are being cleared.
        req0_ready = !rst && can_accept && req0_valid && (grant == 1'b0);
        req1_ready = !rst && can_accept && req1_valid && (grant == 1'b1);

        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (rsp_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign accept    = has_req && can_accept && !rst;
    assign rsp_valid = (state == FULL);

    // ------------------------------------------------------------------
    // Response data, round-robin pointer and condition codes
    // ------------------------------------------------------------------
    // Data fields only change on accept; a plain drain leaves them holding
    // the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id  <= 1'b0;
            rsp_out <= '0;
            rsp_cf  <= 3'b000;
            ptr     <= 1'b0;
            cc      <= 3'b000;
        end else if (accept) begin
            rsp_id  <= grant;
            rsp_out <= alu_out;
            rsp_cf  <= alu_cf;
            ptr     <= ~grant;
            if (!grant && req0_set_cc) begin
                cc <= alu_cf;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_sched.sv
module tb_alu_share_sched;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic         req0_ready;
    logic [1:0]   req0_ctrl;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_set_cc;
    logic         req1_valid;
    logic         req1_ready;
    logic [1:0]   req1_ctrl;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_out;
    logic [2:0]   rsp_cf;
    logic [2:0]   cc;

    int checks;
    int errors;

    alu_share_sched #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_ctrl   (req0_ctrl),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_set_cc (req0_set_cc),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_ctrl   (req1_ctrl),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_out     (rsp_out),
        .rsp_cf      (rsp_cf),
        .cc          (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req0_ctrl   = 2'b00;
        req0_a      = '0;
        req0_b      = '0;
        req0_set_cc = 1'b0;
        req1_valid  = 1'b0;
        req1_ctrl   = 2'b00;
        req1_a      = '0;
        req1_b      = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %0b expected 0", rsp_id); end
        checks++; if (rsp_out !== 64'h0) begin errors++; $display("FAIL reset_rsp_out: got %0h expected 0", rsp_out); end
        checks++; if (rsp_cf !== 3'b000) begin errors++; $display("FAIL reset_rsp_cf: got %b expected 000", rsp_cf); end
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL reset_cc: got %b expected 000", cc); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies: got %b expected 00", {req0_ready, req1_ready}); end
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_add();
        req0_valid  = 1'b1;
        req0_ctrl   = 2'b00;
        req0_a      = 64'd5;
        req0_b      = 64'd3;
        req0_set_cc = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0b expected 1", req0_ready); end
        step();
        idle_inputs();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b expected 1", rsp_valid); end
        checks++; if (rsp_out !== 64'd8) begin errors++; $display("FAIL add_out: got %0h expected 8", rsp_out); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL add_id: got %0b expected 0", rsp_id); end
        checks++; if (rsp_cf !== 3'b000) begin errors++; $display("FAIL add_cf: got %b expected 000", rsp_cf); end
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL add_cc: got %b expected 000", cc); end
    endtask

    task automatic test_overflow();
        req0_valid  = 1'b1;
        req0_ctrl   = 2'b00;
        req0_a      = 64'h7FFF_FFFF_FFFF_FFFF;
        req0_b      = 64'd1;
        req0_set_cc = 1'b1;
        step();
        idle_inputs();
        checks++; if (rsp_out !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_out: got %0h expected 8000000000000000", rsp_out); end
        checks++; if (rsp_cf !== 3'b011) begin errors++; $display("FAIL ovf_cf: got %b expected 011", rsp_cf); end
        checks++; if (cc !== 3'b011) begin errors++; $display("FAIL ovf_cc: got %b expected 011", cc); end
    endtask

    task automatic test_port1_sub();
        req1_valid = 1'b1;
        req1_ctrl  = 2'b01;
        req1_a     = 64'h1234;
        req1_b     = 64'h1234;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL sub_ready: got %0b expected 1", req1_ready); end
        step();
        idle_inputs();
        checks++; if (rsp_out !== 64'h0) begin errors++; $display("FAIL sub_out: got %0h expected 0", rsp_out); end
        checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL sub_id: got %0b expected 1", rsp_id); end
        checks++; if (rsp_cf !== 3'b100) begin errors++; $display("FAIL sub_cf: got %b expected 100", rsp_cf); end
        checks++; if (cc !== 3'b011) begin errors++; $display("FAIL sub_cc: got %b expected 011", cc); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   exp_id;
        logic [W-1:0] exp_out;
        int           acc0;
        int           acc1;
        exp_id = 4'b1010;  // bit i = expected id for cycle i: 0,1,0,1
        acc0 = 0;
        acc1 = 0;
        req0_valid  = 1'b1;
        req0_ctrl   = 2'b10;
        req0_a      = 64'hF0;
        req0_b      = 64'h3C;
        req0_set_cc = 1'b0;
        req1_valid  = 1'b1;
        req1_ctrl   = 2'b11;
        req1_a      = 64'hFF;
        req1_b      = 64'hFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (req0_valid && req0_ready) acc0++;
            if (req1_valid && req1_ready) acc1++;
            step();
            exp_out = exp_id[i] ? 64'h0 : 64'h30;
            checks++; if (rsp_id !== exp_id[i]) begin errors++; $display("FAIL rr_id[%0d]: got %0b expected %0b", i, rsp_id, exp_id[i]); end
            checks++; if (rsp_out !== exp_out) begin errors++; $display("FAIL rr_out[%0d]: got %0h expected %0h", i, rsp_out, exp_out); end
        end
        idle_inputs();
        checks++; if (acc0 !== 2) begin errors++; $display("FAIL rr_acc0: got %0d expected 2", acc0); end
        checks++; if (acc1 !== 2) begin errors++; $display("FAIL rr_acc1: got %0d expected 2", acc1); end
        checks++; if (cc !== 3'b011) begin errors++; $display("FAIL rr_cc: got %b expected 011", cc); end
    endtask

    task automatic test_backpressure();
        // Buffer holds the last xor result from port 1 (0, flags 100).
        rsp_ready   = 1'b0;
        req0_valid  = 1'b1;
        req0_ctrl   = 2'b00;
        req0_a      = 64'd10;
        req0_b      = 64'd20;
        req0_set_cc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b expected 0", i, req0_ready); end
            step();
            checks++; if ({rsp_valid, rsp_id, rsp_cf} !== 5'b11100 || rsp_out !== 64'h0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%0b id=%0b cf=%b out=%0h expected v=1 id=1 cf=100 out=0", i, rsp_valid, rsp_id, rsp_cf, rsp_out);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b expected 1", req0_ready); end
        step();
        idle_inputs();
        checks++; if (rsp_valid !== 1'b1 || rsp_out !== 64'd30 || rsp_id !== 1'b0 || rsp_cf !== 3'b000) begin
            errors++; $display("FAIL bp_refill: got v=%0b out=%0h id=%0b cf=%b expected v=1 out=1e id=0 cf=000", rsp_valid, rsp_out, rsp_id, rsp_cf);
        end
        checks++; if (cc !== 3'b011) begin errors++; $display("FAIL bp_cc: got %b expected 011", cc); end
        step();
        checks++; if (rsp_valid !== 1'b0 || rsp_out !== 64'd30) begin
            errors++; $display("FAIL bp_drain: got v=%0b out=%0h expected v=0 out=1e", rsp_valid, rsp_out);
        end
    endtask

    task automatic test_async_reset();
        req0_valid  = 1'b1;
        req0_ctrl   = 2'b00;
        req0_a      = 64'h7FFF_FFFF_FFFF_FFFF;
        req0_b      = 64'd1;
        req0_set_cc = 1'b1;
        step();
        idle_inputs();
        checks++; if (rsp_valid !== 1'b1 || cc !== 3'b011) begin
            errors++; $display("FAIL arst_pre: got v=%0b cc=%b expected v=1 cc=011", rsp_valid, cc);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b expected 0", rsp_valid); end
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL arst_cc: got %b expected 000", cc); end
        rst = 1'b0;
        req0_valid = 1'b1;
        req0_ctrl  = 2'b00;
        req0_a     = 64'd5;
        req0_b     = 64'd3;
        req1_valid = 1'b1;
        req1_ctrl  = 2'b00;
        req1_a     = 64'd100;
        req1_b     = 64'd1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL arst_grant: got %b expected 10", {req0_ready, req1_ready}); end
        step();
        idle_inputs();
        checks++; if (rsp_id !== 1'b0 || rsp_out !== 64'd8) begin
            errors++; $display("FAIL arst_first: got id=%0b out=%0h expected id=0 out=8", rsp_id, rsp_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_overflow();
        test_port1_sub();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Sequencer and arbiter that shares the single `alu` instance of the execute stage between two requesters: port 0 (instruction execute, OPq/arithmetic) and port 1 (auxiliary address/stack-pointer arithmetic). It picks one request per cycle round-robin and drives the ALU. It registers the result in a one-entry response buffer with backpressure. It also owns the architectural condition-code register (CC), which only port-0 operations with `set_cc` update.

## Interface
Parameters:
- `W`, default 64: operand/result width; must match `alu`.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1 each: request present on port 0 / port 1.
- `req0_ready`, `req1_ready`  out  1 each: request accepted this cycle (handshake = valid & ready).
- `req0_ctrl`, `req1_ctrl`  in  2 each: ALU op: 00 add, 01 sub, 10 and, 11 xor.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  W each: signed operands, passed unchanged to `alu` a/b.
- `req0_set_cc`  in  1: accepted port-0 op loads CC.
- `rsp_valid`  out  1: response buffer holds a result.
- `rsp_ready`  in  1: consumer takes the response this cycle.
- `rsp_id`  out  1: requester that owns the response.
- `rsp_out`  out  W: ALU result.
- `rsp_cf`  out  3: flags of this result, {ZF, SF, OF}.
- `cc`  out  3: architectural condition codes, {ZF, SF, OF}.

## Operation
- States: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- `can_accept` = EMPTY, or FULL with `rsp_ready`=1 (drain and refill in the same cycle).
- Grant, combinational:
  - Only one requester valid: that requester wins.
  - Both valid: `ptr` selects the winner.
- Ready: `reqN_ready` = grant==N & `can_accept`. Ready never depends on the other requester's ready.
- ALU inputs: the mux drives `alu` control/a/b from the granted port. With no grant it drives port 0's fields, which are don't-care.
- On accept (edge):
  - `rsp_out` and `rsp_cf` load the ALU output.
  - `rsp_id` loads the grant; `rsp_valid` goes to 1.
  - `ptr` loads the inverse of the granted id.
- On `rsp_valid` & `rsp_ready` with no accept: `rsp_valid` goes to 0 and the data fields hold.
- CC loads the ALU cf at the accept edge only when grant==0 and `req0_set_cc`=1. Port-1 ops never touch CC.
- Transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on `rsp_ready` with no accept.
  - FULL to FULL either on a stall (`rsp_ready`=0) or on drain plus accept.
- Arithmetic: W-bit two's complement, no widening; the `alu` computes overflow. The scheduler never modifies results or flags.

## Timing
- Latency: request accepted at edge k; response visible after edge k, and CC updated after the same edge.
- Throughput: one op per cycle while `rsp_ready` stays high.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_out`=0, `rsp_cf`=000, `cc`=000, `ptr`=0 (port 0 preferred), both readies 0 while `rst` is asserted.
- Reset mid-operation: a held result is discarded with no response, and any CC update in flight is lost.
- Backpressure: while FULL and `rsp_ready`=0, outputs hold stable and both readies are 0.
- Requesters must hold valid and operands stable until accepted.
- Simultaneous events:
  - Drain and accept in the same cycle: the new result replaces the old; no bubble, no loss.
  - Both ports valid on consecutive cycles: grants strictly alternate.

## Structure
- Shared package `alu_pkg`:
  - op codes ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11;
  - flag indices CF_ZF=2, CF_SF=1, CF_OF=0;
  - default width 64.
- One sub-module: the existing `alu`, instantiated once.
- Grant logic, operand mux, response buffer and CC register stay inline.

## Test plan
- Reset, then port 0 add a=5, b=3 with `set_cc`=1 and `rsp_ready`=1: one cycle later `rsp_out`=8, `rsp_id`=0, `rsp_cf`=000, `cc`=000.
- Port 0 add a=0x7FFF_FFFF_FFFF_FFFF, b=1 with `set_cc`=1: `rsp_out`=0x8000_0000_0000_0000, `rsp_cf`=011, `cc`=011.
- Port 1 sub a=b=0x1234: `rsp_out`=0, `rsp_cf`=100, `cc` unchanged from the previous test (011).
- Both ports valid for 4 cycles (port 0 and 0xF0 & 0x3C, port 1 xor 0xFF ^ 0xFF):
  - `rsp_id` sequence is 0,1,0,1;
  - results are 0x30 and 0;
  - each port is accepted exactly twice.
- `rsp_ready`=0 for 3 cycles while FULL with port 0 valid: outputs hold and `req0_ready`=0. Raising `rsp_ready` gives drain plus accept in the same cycle, with the next result on the following cycle.
- Assert `rst` asynchronously between edges while FULL: `rsp_valid` and `cc` go to 0 immediately, and after release port 0 is granted first.
